// File: rtl/address_sequencer_pkg.sv
// Shared encodings for the control-store address sequencer:
// next-address mode codes and the sequencer FSM state.
package address_sequencer_pkg;

   typedef enum logic [2:0] {
      MODE_INC  = 3'b000,
      MODE_JUMP = 3'b001,
      MODE_BRT  = 3'b010,
      MODE_BRF  = 3'b011,
      MODE_CALL = 3'b100,
      MODE_RET  = 3'b101,
      MODE_HOLD = 3'b110,
      MODE_RSVD = 3'b111
   } mode_e;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_TRAPPED = 1'b1
   } state_e;

endpackage

// File: rtl/address_sequencer_stack.sv
// Return-address LIFO for the sequencer. Only the stack pointer is reset;
// entry contents are don't-care until written. Read is combinational from
// entry[SP-1] so a return can use the popped value in the same cycle.
// Callers must not push when full or pop when empty.
module address_sequencer_stack #(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned SP_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [SP_W-1:0]  sp_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [SP_W-1:0]  sp_q;
   logic [SP_W-1:0]  sp_d;
   logic [WIDTH-1:0] entry_q [DEPTH];

   assign full_o  = (sp_q == SP_W'(DEPTH));
   assign empty_o = (sp_q == '0);
   assign sp_o    = sp_q;

   // Occupancy update: push grows, pop shrinks, guarded against over/underrun.
   always_comb begin
      sp_d = sp_q;
      if (push_i && !full_o) begin
         sp_d = sp_q + SP_W'(1);
      end else if (pop_i && !empty_o) begin
         sp_d = sp_q - SP_W'(1);
      end
   end

   // Stack pointer register, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Entry storage: a push writes the slot currently addressed by SP.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push_i && !full_o && (sp_q == SP_W'(i))) begin
            entry_q[i] <= din_i;
         end
      end
   end

   // Top-of-stack read mux (entry[SP-1]); zero when empty.
   always_comb begin
      dout_o = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (sp_q == SP_W'(i + 1)) begin
            dout_o = entry_q[i];
         end
      end
   end

endmodule

// File: rtl/address_sequencer.sv
// Control-store address sequencer: selects the next microinstruction address
// (increment, jump, conditional branch, call, return, hold) and registers it.
// Stack overflow/underflow sets a sticky error flag. Build option
// ADDRESS_SEQUENCER_TRAP_EN sends over/underflow to TRAP_ADDR and locks the
// sequencer there until reset; without it, an overflowing CALL degrades to a
// JUMP and an underflowing RET degrades to an INC.
module address_sequencer
   import address_sequencer_pkg::*;
#(
   parameter int unsigned                CSAI_DATAWIDTH = 11,
   parameter int unsigned                STACK_DEPTH    = 4,
   parameter logic [CSAI_DATAWIDTH-1:0]  RESET_ADDR     = '0,
   parameter logic [CSAI_DATAWIDTH-1:0]  TRAP_ADDR      = '1,
   localparam int unsigned               SP_W           = $clog2(STACK_DEPTH + 1)
) (
   input  logic                      ADDRESS_SEQUENCER_CLOCK_50,
   input  logic                      ADDRESS_SEQUENCER_RESET_InHigh,
   input  logic                      ADDRESS_SEQUENCER_ACK,
   input  logic [2:0]                ADDRESS_SEQUENCER_MODE_InBus,
   input  logic                      ADDRESS_SEQUENCER_COND,
   input  logic [CSAI_DATAWIDTH-1:0] ADDRESS_SEQUENCER_TARGET_InBus,
   output logic [CSAI_DATAWIDTH-1:0] ADDRESS_SEQUENCER_CSAI_OutBus,
   output logic [SP_W-1:0]           ADDRESS_SEQUENCER_SP_OutBus,
   output logic                      ADDRESS_SEQUENCER_STACK_FULL,
   output logic                      ADDRESS_SEQUENCER_STACK_EMPTY,
   output logic                      ADDRESS_SEQUENCER_ERROR
);

   localparam logic [CSAI_DATAWIDTH-1:0] ADDR_ONE = {{(CSAI_DATAWIDTH-1){1'b0}}, 1'b1};

   logic [CSAI_DATAWIDTH-1:0] addr_q;
   logic [CSAI_DATAWIDTH-1:0] addr_d;
   logic [CSAI_DATAWIDTH-1:0] addr_inc;
   state_e                    state_q;
   state_e                    state_d;
   logic                      err_q;
   logic                      err_d;
   logic                      stk_push;
   logic                      stk_pop;
   logic [CSAI_DATAWIDTH-1:0] stk_dout;
   logic                      stk_full;
   logic                      stk_empty;

   assign addr_inc = addr_q + ADDR_ONE;

   address_sequencer_stack #(
      .WIDTH (CSAI_DATAWIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk_i   (ADDRESS_SEQUENCER_CLOCK_50),
      .rst_i   (ADDRESS_SEQUENCER_RESET_InHigh),
      .push_i  (stk_push),
      .pop_i   (stk_pop),
      .din_i   (addr_inc),
      .dout_o  (stk_dout),
      .sp_o    (ADDRESS_SEQUENCER_SP_OutBus),
      .full_o  (stk_full),
      .empty_o (stk_empty)
   );

   // Next-address mux, stack requests, FSM transition and error capture.
   always_comb begin
      addr_d   = addr_q;
      state_d  = state_q;
      err_d    = err_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      if (ADDRESS_SEQUENCER_ACK) begin
         if (state_q == ST_TRAPPED) begin
            addr_d = TRAP_ADDR;
         end else begin
            case (ADDRESS_SEQUENCER_MODE_InBus)
               MODE_INC:  addr_d = addr_inc;
               MODE_JUMP: addr_d = ADDRESS_SEQUENCER_TARGET_InBus;
               MODE_BRT:  addr_d = ADDRESS_SEQUENCER_COND ? ADDRESS_SEQUENCER_TARGET_InBus : addr_inc;
               MODE_BRF:  addr_d = ADDRESS_SEQUENCER_COND ? addr_inc : ADDRESS_SEQUENCER_TARGET_InBus;
               MODE_CALL: begin
                  if (stk_full) begin
                     err_d = 1'b1;
`ifdef ADDRESS_SEQUENCER_TRAP_EN
                     addr_d  = TRAP_ADDR;
                     state_d = ST_TRAPPED;
`else
                     addr_d = ADDRESS_SEQUENCER_TARGET_InBus;
`endif
                  end else begin
                     stk_push = 1'b1;
                     addr_d   = ADDRESS_SEQUENCER_TARGET_InBus;
                  end
               end
               MODE_RET: begin
                  if (stk_empty) begin
                     err_d = 1'b1;
`ifdef ADDRESS_SEQUENCER_TRAP_EN
                     addr_d  = TRAP_ADDR;
                     state_d = ST_TRAPPED;
`else
                     addr_d = addr_inc;
`endif
                  end else begin
                     stk_pop = 1'b1;
                     addr_d  = stk_dout;
                  end
               end
               MODE_HOLD: addr_d = addr_q;
               default:   addr_d = addr_inc;
            endcase
         end
      end
   end

   // Address, FSM state and sticky error registers; async clear wins over any pending update.
   always_ff @(posedge ADDRESS_SEQUENCER_CLOCK_50 or posedge ADDRESS_SEQUENCER_RESET_InHigh) begin
      if (ADDRESS_SEQUENCER_RESET_InHigh) begin
         addr_q  <= RESET_ADDR;
         state_q <= ST_RUN;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign ADDRESS_SEQUENCER_CSAI_OutBus = addr_q;
   assign ADDRESS_SEQUENCER_STACK_FULL  = stk_full;
   assign ADDRESS_SEQUENCER_STACK_EMPTY = stk_empty;
   assign ADDRESS_SEQUENCER_ERROR       = err_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer (W=11, depth 4, reset addr 0, trap 0x7FF).
// A vector table covers the single-cycle modes; hand-written sequences cover
// overflow, underflow and asynchronous reset in mid-cycle.
module tb_address_sequencer;
   import address_sequencer_pkg::*;

   localparam int W = 11;

   logic          clk = 1'b0;
   logic          rst;
   logic          ack;
   logic [2:0]    mode;
   logic          cond;
   logic [W-1:0]  tgt;
   logic [W-1:0]  addr;
   logic [2:0]    sp;
   logic          full;
   logic          empty;
   logic          err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   address_sequencer #(
      .CSAI_DATAWIDTH (11),
      .STACK_DEPTH    (4),
      .RESET_ADDR     (11'h000),
      .TRAP_ADDR      (11'h7FF)
   ) dut (
      .ADDRESS_SEQUENCER_CLOCK_50     (clk),
      .ADDRESS_SEQUENCER_RESET_InHigh (rst),
      .ADDRESS_SEQUENCER_ACK          (ack),
      .ADDRESS_SEQUENCER_MODE_InBus   (mode),
      .ADDRESS_SEQUENCER_COND         (cond),
      .ADDRESS_SEQUENCER_TARGET_InBus (tgt),
      .ADDRESS_SEQUENCER_CSAI_OutBus  (addr),
      .ADDRESS_SEQUENCER_SP_OutBus    (sp),
      .ADDRESS_SEQUENCER_STACK_FULL   (full),
      .ADDRESS_SEQUENCER_STACK_EMPTY  (empty),
      .ADDRESS_SEQUENCER_ERROR        (err)
   );

   typedef struct {
      logic         ack;
      logic [2:0]   mode;
      logic         cond;
      logic [W-1:0] tgt;
      logic [W-1:0] exp_addr;
      logic [2:0]   exp_sp;
      logic         exp_err;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic a, input logic [2:0] m, input logic c,
                               input logic [W-1:0] t, input logic [W-1:0] ea,
                               input logic [2:0] es, input logic ee);
      vec_t v;
      v.ack = a; v.mode = m; v.cond = c; v.tgt = t;
      v.exp_addr = ea; v.exp_sp = es; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [W-1:0] ea,
                            input logic [2:0] es, input logic ee);
      chk({tag, ".addr"},  int'(addr),  int'(ea));
      chk({tag, ".sp"},    int'(sp),    int'(es));
      chk({tag, ".full"},  int'(full),  int'(es == 3'd4));
      chk({tag, ".empty"}, int'(empty), int'(es == 3'd0));
      chk({tag, ".error"}, int'(err),   int'(ee));
      $display("[%0t] %s addr=0x%03h sp=%0d full=%0b empty=%0b err=%0b",
               $time, tag, addr, sp, full, empty, err);
   endtask

   // Drive one transaction before the edge and sample 1 time unit after it.
   task automatic step(input logic a, input logic [2:0] m, input logic c, input logic [W-1:0] t);
      @(negedge clk);
      ack = a; mode = m; cond = c; tgt = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ack = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ack = 1'b0; mode = MODE_INC; cond = 1'b0; tgt = '0;

      vecs[0]  = mk(1, MODE_INC,  0, 11'h000, 11'h001, 3'd0, 0);
      vecs[1]  = mk(1, MODE_INC,  0, 11'h000, 11'h002, 3'd0, 0);
      vecs[2]  = mk(1, MODE_INC,  0, 11'h000, 11'h003, 3'd0, 0);
      vecs[3]  = mk(0, MODE_INC,  0, 11'h000, 11'h003, 3'd0, 0);
      vecs[4]  = mk(1, MODE_JUMP, 0, 11'h7FE, 11'h7FE, 3'd0, 0);
      vecs[5]  = mk(1, MODE_INC,  0, 11'h000, 11'h7FF, 3'd0, 0);
      vecs[6]  = mk(1, MODE_INC,  0, 11'h000, 11'h000, 3'd0, 0);
      vecs[7]  = mk(1, MODE_JUMP, 0, 11'h005, 11'h005, 3'd0, 0);
      vecs[8]  = mk(1, MODE_BRT,  0, 11'h040, 11'h006, 3'd0, 0);
      vecs[9]  = mk(1, MODE_BRT,  1, 11'h040, 11'h040, 3'd0, 0);
      vecs[10] = mk(1, MODE_BRF,  1, 11'h040, 11'h041, 3'd0, 0);
      vecs[11] = mk(1, MODE_BRF,  0, 11'h020, 11'h020, 3'd0, 0);
      vecs[12] = mk(1, MODE_HOLD, 0, 11'h123, 11'h020, 3'd0, 0);
      vecs[13] = mk(1, MODE_RSVD, 0, 11'h123, 11'h021, 3'd0, 0);
      vecs[14] = mk(1, MODE_JUMP, 0, 11'h010, 11'h010, 3'd0, 0);
      vecs[15] = mk(1, MODE_CALL, 0, 11'h100, 11'h100, 3'd1, 0);
      vecs[16] = mk(1, MODE_CALL, 0, 11'h200, 11'h200, 3'd2, 0);
      vecs[17] = mk(0, MODE_RET,  0, 11'h000, 11'h200, 3'd2, 0);
      vecs[18] = mk(1, MODE_RET,  0, 11'h000, 11'h101, 3'd1, 0);
      vecs[19] = mk(1, MODE_RET,  0, 11'h000, 11'h011, 3'd0, 0);
      vecs[20] = mk(0, MODE_CALL, 0, 11'h300, 11'h011, 3'd0, 0);

      // Reset state is visible while reset is still asserted, before any edge.
      #3;
      chk_state("reset", 11'h000, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].ack, vecs[i].mode, vecs[i].cond, vecs[i].tgt);
         chk_state($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_sp, vecs[i].exp_err);
      end

      // Overflow: fill the stack, then a fifth CALL.
      do_reset();
      step(1, MODE_CALL, 0, 11'h100); chk_state("ovf.call1", 11'h100, 3'd1, 0);
      step(1, MODE_CALL, 0, 11'h101); chk_state("ovf.call2", 11'h101, 3'd2, 0);
      step(1, MODE_CALL, 0, 11'h102); chk_state("ovf.call3", 11'h102, 3'd3, 0);
      step(1, MODE_CALL, 0, 11'h103); chk_state("ovf.call4", 11'h103, 3'd4, 0);
`ifdef ADDRESS_SEQUENCER_TRAP_EN
      step(1, MODE_CALL, 0, 11'h150); chk_state("ovf.call5", 11'h7FF, 3'd4, 1);
      step(1, MODE_INC,  0, 11'h000); chk_state("ovf.trapinc", 11'h7FF, 3'd4, 1);
      step(1, MODE_RET,  0, 11'h000); chk_state("ovf.trapret", 11'h7FF, 3'd4, 1);
`else
      step(1, MODE_CALL, 0, 11'h150); chk_state("ovf.call5", 11'h150, 3'd4, 1);
      step(1, MODE_INC,  0, 11'h000); chk_state("ovf.inc", 11'h151, 3'd4, 1);
      step(1, MODE_RET,  0, 11'h000); chk_state("ovf.ret", 11'h103, 3'd3, 1);
`endif

      // Underflow: RET on an empty stack, then async reset clears the error mid-cycle.
      do_reset();
      chk_state("unf.reset", 11'h000, 3'd0, 0);
`ifdef ADDRESS_SEQUENCER_TRAP_EN
      step(1, MODE_RET, 0, 11'h000); chk_state("unf.ret", 11'h7FF, 3'd0, 1);
`else
      step(1, MODE_RET, 0, 11'h000); chk_state("unf.ret", 11'h001, 3'd0, 1);
`endif
      step(0, MODE_INC, 0, 11'h000);
      #2;
      rst = 1'b1;
      #1;
      chk_state("unf.async", 11'h000, 3'd0, 0);
      rst = 1'b0;

      // Reset pulsed in the middle of a cycle that carries a pending RET with SP=2.
      step(1, MODE_CALL, 0, 11'h100); chk_state("mid.call1", 11'h100, 3'd1, 0);
      step(1, MODE_CALL, 0, 11'h200); chk_state("mid.call2", 11'h200, 3'd2, 0);
      @(negedge clk);
      ack = 1'b1; mode = MODE_RET; cond = 1'b0; tgt = '0;
      #2;
      rst = 1'b1;
      #1;
      chk_state("mid.rst", 11'h000, 3'd0, 0);
      ack = 1'b0;
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_state("mid.after", 11'h000, 3'd0, 0);
      step(1, MODE_INC, 0, 11'h000); chk_state("mid.inc", 11'h001, 3'd0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
